// File: rtl/dl11_multi.sv
// dl11_multi: NCH independent DL11-style serial channels behind the DCJ11 bus decoder.
// Each channel exposes RCSR/RBUF/XCSR/XBUF, owns an rx and a tx FIFO, and raises level
// interrupt requests. The host side is a simple per-channel byte handshake.
module dl11_multi #(
    parameter int          NCH   = 2,
    parameter logic [21:0] BASE  = 22'o17777560,
    parameter int          DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_init,
    input  logic [21:0]          bus_addr,
    input  logic                 bus_rd,
    input  logic                 bus_wr,
    input  logic                 bus_byte,
    input  logic [15:0]          bus_wdata,
    output logic                 bus_hit,
    output logic [15:0]          bus_rdata,
    output logic [NCH-1:0]       irq_rx,
    output logic [NCH-1:0]       irq_tx,
    input  logic [NCH-1:0]       host_rx_valid,
    input  logic [8*NCH-1:0]     host_rx_data,
    output logic [NCH-1:0]       host_tx_valid,
    output logic [8*NCH-1:0]     host_tx_data,
    input  logic [NCH-1:0]       host_tx_ready
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [18:0]     BASE_PAGE = BASE[21:3];

    // bus_init behaves exactly like rst
    logic        clr;
    logic [18:0] addr_page;
    logic [19:0] page_off;
    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic        wr_lo;
    logic [15:0] sel_word;
    logic [15:0] rdata_reg;
    logic [15:0] ch_rdata [NCH];

    // only the low data byte is ever stored; the high byte is intentionally ignored
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus_wdata[15:8];

    assign clr       = rst | bus_init;
    assign addr_page = bus_addr[21:3];
    assign page_off  = {1'b0, addr_page} - {1'b0, BASE_PAGE};
    assign bus_hit   = (addr_page >= BASE_PAGE) && (page_off < 20'(NCH));
    assign ch_sel    = page_off[2:0];
    assign reg_sel   = bus_addr[2:1];
    // a byte write to the odd address touches only the high byte, which holds nothing
    assign wr_lo     = bus_wr && (!bus_byte || !bus_addr[0]);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [7:0]    rx_mem [DEPTH];
            logic [AW-1:0] rx_wp_reg;
            logic [AW-1:0] rx_rp_reg;
            logic [CW-1:0] rx_cnt_reg;
            logic          or_reg;
            logic          rie_reg;
            logic [7:0]    tx_mem [DEPTH];
            logic [AW-1:0] tx_wp_reg;
            logic [AW-1:0] tx_rp_reg;
            logic [CW-1:0] tx_cnt_reg;
            logic          xie_reg;
            logic          brk_reg;
            logic          irq_rx_reg;
            logic          irq_tx_reg;

            logic          ch_hit;
            logic          rx_empty;
            logic          rx_full;
            logic          rbuf_rd;
            logic          rx_pop;
            logic          rx_push;
            logic          rx_ovf;
            logic          tx_empty;
            logic          tx_full;
            logic          tx_pop;
            logic          tx_push;
            logic          rcsr_wr;
            logic          xcsr_wr;
            logic [7:0]    rx_head;
            logic [15:0]   rd_word;

            assign ch_hit   = bus_hit && (ch_sel == 3'(gi));
            assign rx_empty = (rx_cnt_reg == '0);
            assign rx_full  = (rx_cnt_reg == FULL_CNT);
            assign tx_empty = (tx_cnt_reg == '0);
            assign tx_full  = (tx_cnt_reg == FULL_CNT);

            // a pop frees a slot in the same cycle, so a push onto a full FIFO still lands
            assign rbuf_rd  = ch_hit && bus_rd && (reg_sel == 2'd1);
            assign rx_pop   = rbuf_rd && !rx_empty;
            assign rx_push  = host_rx_valid[gi] && (!rx_full || rx_pop);
            assign rx_ovf   = host_rx_valid[gi] && rx_full && !rx_pop;
            assign tx_pop   = !tx_empty && host_tx_ready[gi];
            assign tx_push  = ch_hit && wr_lo && (reg_sel == 2'd3) && (!tx_full || tx_pop);
            assign rcsr_wr  = ch_hit && wr_lo && (reg_sel == 2'd0);
            assign xcsr_wr  = ch_hit && wr_lo && (reg_sel == 2'd2);
            assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp_reg];

            // rx FIFO storage; contents are don't-care once pointers are cleared
            always_ff @(posedge clk) begin
                if (!clr && rx_push)
                    rx_mem[rx_wp_reg] <= host_rx_data[8*gi +: 8];
            end

            // rx pointers, occupancy, sticky overrun and RIE
            always_ff @(posedge clk) begin
                if (clr) begin
                    rx_wp_reg  <= '0;
                    rx_rp_reg  <= '0;
                    rx_cnt_reg <= '0;
                    or_reg     <= 1'b0;
                    rie_reg    <= 1'b0;
                end else begin
                    if (rx_push)
                        rx_wp_reg <= rx_wp_reg + 1'b1;
                    if (rx_pop)
                        rx_rp_reg <= rx_rp_reg + 1'b1;
                    rx_cnt_reg <= rx_cnt_reg + CW'(rx_push) - CW'(rx_pop);
                    if (rx_ovf)
                        or_reg <= 1'b1;
                    else if (rbuf_rd)
                        or_reg <= 1'b0;
                    if (rcsr_wr)
                        rie_reg <= bus_wdata[6];
                end
            end

            // tx FIFO storage
            always_ff @(posedge clk) begin
                if (!clr && tx_push)
                    tx_mem[tx_wp_reg] <= bus_wdata[7:0];
            end

            // tx pointers, occupancy, XIE and BRK
            always_ff @(posedge clk) begin
                if (clr) begin
                    tx_wp_reg  <= '0;
                    tx_rp_reg  <= '0;
                    tx_cnt_reg <= '0;
                    xie_reg    <= 1'b0;
                    brk_reg    <= 1'b0;
                end else begin
                    if (tx_push)
                        tx_wp_reg <= tx_wp_reg + 1'b1;
                    if (tx_pop)
                        tx_rp_reg <= tx_rp_reg + 1'b1;
                    tx_cnt_reg <= tx_cnt_reg + CW'(tx_push) - CW'(tx_pop);
                    if (xcsr_wr) begin
                        xie_reg <= bus_wdata[6];
                        brk_reg <= bus_wdata[0];
                    end
                end
            end

            // level interrupt requests, registered one cycle behind the status they follow
            always_ff @(posedge clk) begin
                if (clr) begin
                    irq_rx_reg <= 1'b0;
                    irq_tx_reg <= 1'b0;
                end else begin
                    irq_rx_reg <= rie_reg && !rx_empty;
                    irq_tx_reg <= xie_reg && !tx_full;
                end
            end

            // read word for this channel's addressed register
            always_comb begin
                rd_word = 16'h0000;
                case (reg_sel)
                    2'd0:    rd_word = {8'h00, !rx_empty, rie_reg, 6'b0};
                    2'd1:    rd_word = {or_reg, or_reg, 6'b0, rx_head};
                    2'd2:    rd_word = {8'h00, !tx_full, xie_reg, 5'b0, brk_reg};
                    default: rd_word = 16'h0000;
                endcase
            end

            assign ch_rdata[gi]               = rd_word;
            assign irq_rx[gi]                 = irq_rx_reg;
            assign irq_tx[gi]                 = irq_tx_reg;
            assign host_tx_valid[gi]          = !tx_empty;
            assign host_tx_data[8*gi +: 8]    = tx_mem[tx_rp_reg];
        end
    endgenerate

    // pick the addressed channel's read word
    always_comb begin
        sel_word = 16'h0000;
        for (int c = 0; c < NCH; c++) begin
            if (ch_sel == 3'(c))
                sel_word = ch_rdata[c];
        end
    end

    // read data is captured on bus_rd and held until the next read
    always_ff @(posedge clk) begin
        if (clr)
            rdata_reg <= 16'h0000;
        else if (bus_rd)
            rdata_reg <= bus_hit ? sel_word : 16'h0000;
    end

    assign bus_rdata = rdata_reg;

endmodule

// File: doc/dl11_multi.md
Name: dl11_multi

Overview:
- Parametrised successor to the single-channel console register emulation. Provides NCH DL11-style serial channels: RCSR/RBUF/XCSR/XBUF per channel, receive/transmit FIFOs, overrun flag, interrupt-enable bits and level interrupt requests.
- Sits between the DCJ11 bus-cycle decoder (latched address, read/write strobes) and the host-side byte handshake to the ODT/console microcontroller.

Parameters:
- NCH, 2, number of channels (1..8).
- BASE, 22'o17777560, physical address of channel 0 RCSR; 8-byte aligned; channel c occupies BASE+8*c .. BASE+8*c+6.
- DEPTH, 16, FIFO depth per direction per channel; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- bus_init  in  1  DCJ11 bus INIT (GP code 014); one-cycle pulse, same effect as rst.
- bus_addr  in  22  latched physical address of the current cycle (BS_EXT already qualified).
- bus_rd  in  1  one-cycle read strobe.
- bus_wr  in  1  one-cycle write strobe.
- bus_byte  in  1  byte write; bus_addr[0] selects the high byte.
- bus_wdata  in  16  write data.
- bus_hit  out  1  combinational: bus_addr decodes to a channel register; feeds NXM suppression.
- bus_rdata  out  16  registered read data.
- irq_rx  out  NCH  receive interrupt request, level.
- irq_tx  out  NCH  transmit interrupt request, level.
- host_rx_valid  in  NCH  host presents a byte for channel c.
- host_rx_data  in  8*NCH  byte for channel c at [8c+7:8c].
- host_tx_valid  out  NCH  tx FIFO of channel c is non-empty.
- host_tx_data  out  8*NCH  tx FIFO head of channel c.
- host_tx_ready  in  NCH  host takes the head byte of channel c.

Behaviour:
- Decode: bus_hit=1 iff bus_addr[21:3] is in BASE[21:3] .. BASE[21:3]+NCH-1. Channel = bus_addr[21:3]-BASE[21:3]. Register = bus_addr[2:1]: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF.
- Read latency: bus_rdata valid on the cycle after bus_rd and held until the next bus_rd. A bus_rd with bus_hit=0 returns 16'h0000.
- RCSR read: {8'b0, DONE, RIE, 6'b0}. DONE = rx FIFO non-empty.
- RBUF read: {OR, OR, 6'b0, head}, where head is the rx FIFO head byte, or 8'h00 when empty. The read pops one entry when non-empty and clears OR. Each bus_rd pulse pops at most one entry.
- XCSR read: {8'b0, RDY, XIE, 5'b0, BRK}. RDY = tx FIFO not full.
- XBUF read: returns 0.
- Writes:
  - RCSR: bit6 -> RIE.
  - XCSR: bit6 -> XIE, bit0 -> BRK (stored only, no other effect).
  - RBUF: ignored.
  - XBUF: bus_wdata[7:0] pushed to the tx FIFO. Pushes while full are dropped with no flag.
  - Byte writes with bus_addr[0]=1 affect nothing; byte writes with bus_addr[0]=0 act on the low byte as above.
- Rx path: the block accepts every host_rx_valid cycle (no ready signal). If the FIFO is full, the byte is discarded and OR is set (sticky).
- Rx simultaneous events: host push and RBUF pop in the same cycle while full: pop, then accept the push; OR not set. Push and pop while empty: FIFO ends with one entry; the read returns 8'h00.
- Tx path: host_tx_valid = non-empty; host_tx_data = head. A pop occurs on host_tx_valid & host_tx_ready.
- Tx simultaneous events: XBUF push and host pop in the same cycle while full: the push is accepted.
- FIFO implementation: read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH. The count has $clog2(DEPTH)+1 bits; full is count==DEPTH, empty is count==0.
- irq_rx[c] = RIE & DONE. irq_tx[c] = XIE & RDY. Both are registered, one cycle after the state change.
- Reset (rst or bus_init), synchronous:
  - Pointers and counts cleared, RIE=XIE=BRK=OR=0.
  - bus_rdata=0, irq_rx=irq_tx=0, host_tx_valid=0.
  - After reset RDY=1, so irq_tx follows XIE as soon as it is set.
  - Reset mid-operation discards FIFO contents and takes priority over a same-cycle bus or host event.
- Channels are fully independent; concurrent host events on different channels are all serviced in the same cycle.

Test Plan:
- Reset, then read BASE+0 and BASE+4 -> next-cycle bus_rdata 16'o000000 and 16'o000200. irq_rx=irq_tx=0. Read of BASE+8*NCH -> bus_hit=0, data 0.
- Push 8'h41 on ch1 host_rx, read RCSR1 -> 16'o000200. Read RBUF1 -> 16'h0041. Read RCSR1 again -> 16'o000000.
- Push DEPTH+1 bytes on ch0 rx -> RBUF0 read returns 16'hC000|first byte. Second read has bits 15:14 clear. Total DEPTH bytes readable; the byte pushed after full is lost.
- Write XBUF0 DEPTH times -> XCSR0 RDY=0 on read. Extra write dropped. Host pops with host_tx_ready=1 in order 0..DEPTH-1; RDY returns to 1 after the first pop.
- Write RCSR0=16'o000100 with rx empty -> irq_rx[0]=0. Push a byte -> irq_rx[0]=1 one cycle later. Read RBUF0 -> irq_rx[0]=0. bus_init -> RIE cleared, readback 0.
- Byte write 16'hFF41 to XBUF0+1 (high byte) -> FIFO unchanged. Byte write to XBUF0 -> 8'h41 queued.
